// File: rtl/pcie_tlp_pkg.sv
// Shared TLP constants and the transmit FSM state type for the MWr32
// transmit path.
package pcie_tlp_pkg;

    localparam logic [1:0] FMT_3DW_DATA = 2'b10;
    localparam logic [4:0] TYPE_MEM     = 5'b00000;
    localparam int         MWR32_BEATS  = 8;
    localparam logic [3:0] FIRST_BE_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        CREDIT,
        REQ,
        XMIT
    } tx_state_t;

endpackage

// File: rtl/pcie_mwr_beat_mux.sv
// Selects one 16-bit beat of a 3DW-header, 1DW-payload Memory Write TLP.
// Beats are sent most-significant half first.
module pcie_mwr_beat_mux
    import pcie_tlp_pkg::*;
(
    input  logic [31:2] addr,
    input  logic [31:0] data,
    input  logic [15:0] req_id,
    input  logic [7:0]  tag,
    input  logic [2:0]  tc,
    input  logic [2:0]  idx,
    output logic [15:0] beat
);

    // Length is fixed at one DW; only the first DW byte enables are used.
    always_comb begin
        beat = '0;
        case (idx)
            3'd0: beat = {1'b0, FMT_3DW_DATA, TYPE_MEM, 1'b0, tc, 4'b0000};
            3'd1: beat = {1'b0, 1'b0, 2'b00, 2'b00, 10'd1};
            3'd2: beat = req_id;
            3'd3: beat = {tag, 4'h0, FIRST_BE_ALL};
            3'd4: beat = addr[31:16];
            3'd5: beat = {addr[15:2], 2'b00};
            3'd6: beat = data[31:16];
            3'd7: beat = data[15:0];
            default: beat = '0;
        endcase
    end

endmodule

// File: rtl/pcie_tx_mwr.sv
// Transmit-side Memory Write TLP source for the VC0 TX interface: latches a
// one-word command, checks posted credits, and streams eight 16-bit beats.
module pcie_tx_mwr
    import pcie_tlp_pkg::*;
#(
    parameter int         CREDIT_CHECK = 1,
    parameter logic [2:0] TC           = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send,
    input  logic [31:0] send_addr,
    input  logic [31:0] send_data,
    input  logic [7:0]  bus_num,
    input  logic [4:0]  dev_num,
    input  logic [2:0]  func_num,
    input  logic        bme,
    output logic        busy,
    output logic        done,
    output logic        dropped,
    output logic [15:0] pkt_count,
    output logic        tx_req,
    input  logic        tx_rdy,
    input  logic [8:0]  tx_ca_ph,
    input  logic [12:0] tx_ca_pd,
    input  logic        tx_ca_p_recheck,
    output logic [15:0] tx_data,
    output logic        tx_st,
    output logic        tx_end,
    output logic        tx_nlfy
);

    localparam logic [2:0] LAST_IDX = 3'(MWR32_BEATS - 1);

    tx_state_t   state;
    logic [2:0]  idx;
    logic [7:0]  tag;
    logic [31:2] cmd_addr;
    logic [31:0] cmd_data;
    logic [15:0] cmd_req_id;
    logic [15:0] beat;
    logic        credit_ok;
    logic        in_xmit;

    assign credit_ok = (CREDIT_CHECK == 0) || ((tx_ca_ph != '0) && (tx_ca_pd != '0));

    // Any send that does not start a packet (busy, or bus mastering off)
    // is reported back through dropped rather than queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            tag        <= '0;
            cmd_addr   <= '0;
            cmd_data   <= '0;
            cmd_req_id <= '0;
            pkt_count  <= '0;
            done       <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            done    <= 1'b0;
            dropped <= send && !((state == IDLE) && bme);
            case (state)
                IDLE: begin
                    if (send && bme) begin
                        cmd_addr   <= send_addr[31:2];
                        cmd_data   <= send_data;
                        cmd_req_id <= {bus_num, dev_num, func_num};
                        state      <= CREDIT;
                    end
                end
                CREDIT: begin
                    if (credit_ok) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (tx_rdy) begin
                        state <= XMIT;
                        idx   <= '0;
                    end else if (tx_ca_p_recheck) begin
                        state <= CREDIT;
                    end
                end
                XMIT: begin
                    if (tx_rdy) begin
                        if (idx == LAST_IDX) begin
                            state     <= IDLE;
                            idx       <= '0;
                            done      <= 1'b1;
                            pkt_count <= pkt_count + 16'd1;
                            tag       <= tag + 8'd1;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    pcie_mwr_beat_mux u_beat_mux (
        .addr   (cmd_addr),
        .data   (cmd_data),
        .req_id (cmd_req_id),
        .tag    (tag),
        .tc     (TC),
        .idx    (idx),
        .beat   (beat)
    );

    assign in_xmit = (state == XMIT);
    assign busy    = (state != IDLE);
    assign tx_req  = (state == REQ);
    assign tx_st   = in_xmit && (idx == 3'd0);
    assign tx_end  = in_xmit && (idx == LAST_IDX);
    assign tx_data = in_xmit ? beat : 16'h0000;
    assign tx_nlfy = 1'b0;

endmodule

// File: tb/tb_pcie_tx_mwr.sv
// Self-checking bench for pcie_tx_mwr: an abstract packet model predicts
// every output each cycle, with literal expectations for the directed cases.
module tb_pcie_tx_mwr;

    localparam logic [2:0] TC_V = 3'd0;

    logic        clk;
    logic        rst;
    logic        send;
    logic [31:0] send_addr;
    logic [31:0] send_data;
    logic [7:0]  bus_num;
    logic [4:0]  dev_num;
    logic [2:0]  func_num;
    logic        bme;
    logic        busy;
    logic        done;
    logic        dropped;
    logic [15:0] pkt_count;
    logic        tx_req;
    logic        tx_rdy;
    logic [8:0]  tx_ca_ph;
    logic [12:0] tx_ca_pd;
    logic        tx_ca_p_recheck;
    logic [15:0] tx_data;
    logic        tx_st;
    logic        tx_end;
    logic        tx_nlfy;

    int errors = 0;
    int checks = 0;
    logic run_checks = 1'b0;
    logic [15:0] cap [$];

    // Model: phase 0 idle, 1 waiting for credits, 2 requesting, 3 sending.
    int          m_phase;
    int          m_beat;
    logic [7:0]  m_tag;
    logic [15:0] m_count;
    logic        m_done;
    logic        m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [7:0]  m_bus;
    logic [4:0]  m_dev;
    logic [2:0]  m_func;

    pcie_tx_mwr #(
        .CREDIT_CHECK (1),
        .TC           (TC_V)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .send            (send),
        .send_addr       (send_addr),
        .send_data       (send_data),
        .bus_num         (bus_num),
        .dev_num         (dev_num),
        .func_num        (func_num),
        .bme             (bme),
        .busy            (busy),
        .done            (done),
        .dropped         (dropped),
        .pkt_count       (pkt_count),
        .tx_req          (tx_req),
        .tx_rdy          (tx_rdy),
        .tx_ca_ph        (tx_ca_ph),
        .tx_ca_pd        (tx_ca_pd),
        .tx_ca_p_recheck (tx_ca_p_recheck),
        .tx_data         (tx_data),
        .tx_st           (tx_st),
        .tx_end          (tx_end),
        .tx_nlfy         (tx_nlfy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet words derived arithmetically from the latched command fields.
    function automatic logic [15:0] expected_word(input int i);
        logic [31:0] w;
        case (i)
            0: w = 32'h4000 | (32'(TC_V) * 16);
            1: w = 32'd1;
            2: w = 32'(m_bus) * 256 + 32'(m_dev) * 8 + 32'(m_func);
            3: w = 32'(m_tag) * 256 + 15;
            4: w = m_addr / 65536;
            5: w = (m_addr % 65536) & 32'hFFFC;
            6: w = m_data / 65536;
            default: w = m_data % 65536;
        endcase
        return w[15:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_beat  <= 0;
            m_tag   <= '0;
            m_count <= '0;
            m_done  <= 1'b0;
            m_drop  <= 1'b0;
            m_addr  <= '0;
            m_data  <= '0;
            m_bus   <= '0;
            m_dev   <= '0;
            m_func  <= '0;
        end else begin
            m_drop <= send && !(m_phase == 0 && bme);
            m_done <= 1'b0;
            if (m_phase == 0 && send && bme) begin
                m_addr  <= send_addr;
                m_data  <= send_data;
                m_bus   <= bus_num;
                m_dev   <= dev_num;
                m_func  <= func_num;
                m_phase <= 1;
            end else if (m_phase == 1 && tx_ca_ph != 0 && tx_ca_pd != 0) begin
                m_phase <= 2;
            end else if (m_phase == 2 && tx_rdy) begin
                m_phase <= 3;
                m_beat  <= 0;
            end else if (m_phase == 2 && tx_ca_p_recheck) begin
                m_phase <= 1;
            end else if (m_phase == 3 && tx_rdy) begin
                if (m_beat == 7) begin
                    m_phase <= 0;
                    m_done  <= 1'b1;
                    m_count <= m_count + 16'd1;
                    m_tag   <= m_tag + 8'd1;
                end else begin
                    m_beat <= m_beat + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && run_checks) begin
            check("busy", busy, m_phase != 0);
            check("tx_req", tx_req, m_phase == 2);
            check("tx_st", tx_st, m_phase == 3 && m_beat == 0);
            check("tx_end", tx_end, m_phase == 3 && m_beat == 7);
            check("done", done, m_done);
            check("dropped", dropped, m_drop);
            check("pkt_count", pkt_count, m_count);
            check("tx_nlfy", tx_nlfy, 0);
            if (m_phase == 3) begin
                check("tx_data", tx_data, expected_word(m_beat));
                if (tx_rdy) cap.push_back(tx_data);
            end
        end
    end

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        send      = 1'b1;
        send_addr = a;
        send_data = d;
        @(posedge clk); #1;
        send = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic wait_tx_req(input int max_cycles);
        int n = 0;
        while (!tx_req && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("tx_req_timeout", tx_req, 1);
    endtask

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] exp1 [8];
        exp1 = '{16'h4000, 16'h0001, 16'h0100, 16'h000F,
                 16'h0000, 16'h1004, 16'hDEAD, 16'hBEEF};

        rst = 1'b1; send = 1'b0; send_addr = '0; send_data = '0;
        bus_num = 8'd1; dev_num = 5'd0; func_num = 3'd0; bme = 1'b1;
        tx_rdy = 1'b1; tx_ca_ph = 9'd8; tx_ca_pd = 13'd8; tx_ca_p_recheck = 1'b0;

        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_tx_req", tx_req, 0);
        check("reset_pkt_count", pkt_count, 0);
        check("reset_tx_data", tx_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_checks = 1'b1;

        // Basic packet with exact cycle-by-cycle timing
        cap.delete();
        apply_stimulus(32'h0000_1004, 32'hDEAD_BEEF);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            check("t1_busy", busy, c <= 10);
            check("t1_tx_req", tx_req, c == 2);
            check("t1_tx_st", tx_st, c == 3);
            check("t1_tx_end", tx_end, c == 10);
            check("t1_done", done, c == 11);
        end
        check("t1_pkt_count", pkt_count, 16'd1);
        check("t1_beat_count", cap.size(), 8);
        for (int i = 0; i < 8 && i < cap.size(); i++) check("t1_beat", cap[i], exp1[i]);

        // No header credits: request must wait
        @(posedge clk); #1;
        tx_ca_ph = 9'd0;
        apply_stimulus(32'h0000_2008, 32'h1234_5678);
        repeat (20) begin
            @(negedge clk);
            check("t2_req_held", tx_req, 0);
        end
        @(posedge clk); #1;
        tx_ca_ph = 9'd4;
        wait_idle(40);
        check("t2_pkt_count", pkt_count, 16'd2);

        // Core stalls for three cycles on beat 5
        cap.delete();
        apply_stimulus(32'h0000_1004, 32'hCAFE_F00D);
        repeat (7) @(posedge clk);
        #1 tx_rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t3_stall_data", tx_data, 16'h1004);
        end
        @(posedge clk); #1;
        tx_rdy = 1'b1;
        wait_idle(30);
        check("t3_beat_count", cap.size(), 8);
        if (cap.size() == 8) begin
            check("t3_beat5", cap[5], 16'h1004);
            check("t3_beat6", cap[6], 16'hCAFE);
        end
        check("t3_pkt_count", pkt_count, 16'd3);

        // Credit recheck while waiting for grant
        @(posedge clk); #1;
        tx_rdy = 1'b0;
        apply_stimulus(32'h0000_3000, 32'h0BAD_F00D);
        wait_tx_req(10);
        @(posedge clk); #1;
        tx_ca_ph = 9'd0;
        tx_ca_p_recheck = 1'b1;
        @(posedge clk); #1;
        tx_ca_p_recheck = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t4_req_dropped", tx_req, 0);
            check("t4_busy", busy, 1);
        end
        @(posedge clk); #1;
        tx_ca_ph = 9'd1;
        tx_rdy = 1'b1;
        wait_idle(30);
        check("t4_pkt_count", pkt_count, 16'd4);

        // Rejected sends: bus mastering off, then a send while busy
        @(posedge clk); #1;
        bme = 1'b0;
        apply_stimulus(32'h0000_5000, 32'h5555_5555);
        @(negedge clk);
        check("t5_bme_dropped", dropped, 1);
        check("t5_bme_busy", busy, 0);
        bme = 1'b1;
        apply_stimulus(32'h0000_6000, 32'h1111_2222);
        apply_stimulus(32'h0000_7000, 32'h3333_3333);
        @(negedge clk);
        check("t5_busy_dropped", dropped, 1);
        @(posedge clk); #1;
        bme = 1'b0;
        wait_idle(30);
        check("t5_pkt_count", pkt_count, 16'd5);
        bme = 1'b1;

        // 257 back-to-back packets: tags wrap after 255
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_reset_count", pkt_count, 0);
        cap.delete();
        for (int k = 0; k < 257; k++) begin
            apply_stimulus(32'(k) * 4, 32'(k));
            repeat (9) @(posedge clk);
        end
        wait_idle(30);
        check("t6_pkt_count", pkt_count, 16'd257);
        check("t6_beat_count", cap.size(), 257 * 8);
        for (int k = 0; k < 257 && (8 * k + 3) < cap.size(); k++) begin
            check("t6_tag", cap[8 * k + 3], 32'((k % 256) * 256 + 15));
        end

        // Asynchronous reset while beat 3 is on the bus
        apply_stimulus(32'h0000_8000, 32'h8888_9999);
        repeat (5) @(posedge clk);
        #2;
        check("t7_mid_packet", tx_data, 16'h010F);
        rst = 1'b1;
        #1;
        check("t7_rst_busy", busy, 0);
        check("t7_rst_tx_req", tx_req, 0);
        check("t7_rst_tx_st", tx_st, 0);
        check("t7_rst_tx_end", tx_end, 0);
        check("t7_rst_tx_data", tx_data, 0);
        check("t7_rst_done", done, 0);
        check("t7_rst_dropped", dropped, 0);
        check("t7_rst_pkt_count", pkt_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) begin
            @(negedge clk);
            check("t7_no_done", done, 0);
            check("t7_idle", busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pcie_tx_mwr.md
Name: pcie_tx_mwr

Overview:
Transmit-side TLP source for the x1 PCIe core's VC0 transmit TLP interface, replacing the tied-off tx_req/tx_st/tx_end/tx_data inputs.
- Accepts a single-word write command from fabric logic (e.g. the LED/counter status).
- Builds a 32-bit-address Memory Write TLP: 3DW header plus 1DW payload.
- Checks posted credits, runs the tx_req/tx_rdy handshake and streams 8 x 16-bit beats.

Parameters:
CREDIT_CHECK, 1, 1 = wait for tx_ca_ph != 0 and tx_ca_pd != 0 before requesting; 0 = skip the credit check.
TC, 3'd0, traffic class placed in header DW0.

Ports:
clk  input  1  core system clock (125 MHz sys_clk_125)
rst  input  1  reset, asynchronous, active-high
send  input  1  single-cycle command strobe
send_addr  input  32  byte address; bits [1:0] ignored and sent as 0
send_data  input  32  payload DW
bus_num  input  8  requester bus number
dev_num  input  5  requester device number
func_num  input  3  requester function number
bme  input  1  bus-master enable (cmd_reg_out[2])
busy  output  1  command in progress
done  output  1  1-cycle pulse after the last beat is accepted
dropped  output  1  1-cycle pulse when a send is rejected
pkt_count  output  16  count of completed TLPs, wraps
tx_req  output  1  transmit request to the core
tx_rdy  input  1  core grant / beat accept
tx_ca_ph  input  9  posted header credits
tx_ca_pd  input  13  posted data credits
tx_ca_p_recheck  input  1  core request to re-evaluate posted credits
tx_data  output  16  TLP beat
tx_st  output  1  first beat marker
tx_end  output  1  last beat marker
tx_nlfy  output  1  nullify; always 0

Behaviour:
- Reset (asynchronous): state IDLE; tag=0; pkt_count=0; all outputs 0; latched command cleared. Reset mid-packet abandons the TLP immediately and produces no done.
- FSM states: IDLE, CREDIT, REQ, XMIT. busy = (state != IDLE).
- IDLE:
  - send=1 and bme=1: latch send_addr, send_data, {bus_num,dev_num,func_num}; go to CREDIT.
  - send=1 and bme=0: dropped pulses the next cycle; stay in IDLE.
- send while busy: ignored; dropped pulses the next cycle.
- CREDIT: go to REQ when CREDIT_CHECK=0, or when tx_ca_ph != 0 and tx_ca_pd != 0. Otherwise wait indefinitely.
- REQ:
  - tx_req=1.
  - tx_ca_p_recheck=1 with tx_rdy=0: return to CREDIT, dropping tx_req for at least one cycle.
  - tx_rdy=1: go to XMIT. Recheck has priority only when tx_rdy=0.
- XMIT:
  - tx_req=0. Beat index idx 0..7; outputs are combinational from the registered state and idx.
  - tx_st = (idx==0); tx_end = (idx==7).
  - A beat is accepted in any cycle where tx_rdy=1, and idx increments.
  - tx_rdy=0 holds idx, tx_data, tx_st and tx_end unchanged.
  - Beat accepted at idx 7: go to IDLE, done pulses next cycle, pkt_count+1, tag+1 (wraps 255->0).
- Beat contents (MSB first):
  - w0 = {1'b0, 2'b10, 5'b00000, 1'b0, TC, 4'b0}
  - w1 = {1'b0, 1'b0, 2'b00, 2'b00, 10'd1}
  - w2 = {bus, dev, func}
  - w3 = {tag, 4'h0, 4'hF}
  - w4 = addr[31:16]
  - w5 = {addr[15:2], 2'b00}
  - w6 = data[31:16]
  - w7 = data[15:0]
- Latency with credits present and tx_rdy=1, send sampled at edge N:
  - busy high for cycles N+1..N+10.
  - tx_req high in cycle N+2.
  - tx_st in cycle N+3; tx_end in cycle N+10.
  - done pulses in cycle N+11.
  - A new send is accepted from cycle N+11.
- bme falling mid-operation does not abort the TLP in flight.

Decomposition:
- Package pcie_tlp_pkg holds:
  - constants FMT_3DW_DATA=2'b10, TYPE_MEM=5'b00000, MWR32_BEATS=8, FIRST_BE_ALL=4'hF;
  - the FSM state enumeration.
- Sub-module pcie_mwr_beat_mux (combinational): takes the latched command, tag, TC and idx; returns the tx_data beat.

Test Plan:
1. Reset release, tx_rdy=1, ph=8, pd=8, bus=1/dev=0/func=0; send addr=32'h0000_1004, data=32'hDEAD_BEEF -> tx_req cycle N+2; beats 4000,0001,0100,000F,0000,1004,DEAD,BEEF; tx_st only on 4000; tx_end only on BEEF; done at N+11; pkt_count=1.
2. ph=0 at send; ph set to 4 after 20 cycles -> tx_req stays 0 for those 20 cycles, then the TLP is sent normally.
3. tx_rdy held 0 for 3 cycles while idx=5 -> tx_data stays 1004 for those cycles, with no duplicated or skipped beat.
4. In REQ with tx_rdy=0, pulse tx_ca_p_recheck with ph=0 -> tx_req drops and the FSM waits in CREDIT. Restoring ph to 1 -> transmission proceeds.
5. bme=0 send -> dropped pulse, no tx_req. send during busy -> dropped pulse, and the in-flight TLP is unchanged.
6. Send 257 TLPs back-to-back -> tag sequence 00..FF,00; pkt_count=257. Async rst asserted during idx 3 -> all outputs 0 immediately and no done.
